// File: rtl/noc_flow_monitor.sv
`default_nettype none
// ============================================================================
// Module   : noc_flow_monitor
// Brief    : passive per-channel tag scoreboard: destination, latency, overflow,
//            spurious-egress and global deadlock checks for a router mesh
// Revision : 1.0
// ============================================================================
module noc_flow_monitor #(
   parameter int ROWS       = 2,
   parameter int COLS       = 2,
   parameter int PORTS      = 5,
   parameter int FLIT_W     = 64,
   parameter int DEST_W     = 16,
   parameter int TAG_DEPTH  = 8,
   parameter int TS_W       = 16,
   parameter int MAX_LAT    = 256,
   parameter int DL_TIMEOUT = 1024
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             enable,
   input  logic                                             clear,
   input  logic [ROWS*COLS*PORTS*FLIT_W-1:0]                flit_in,
   input  logic [ROWS*COLS*PORTS-1:0]                       valid_in,
   input  logic [ROWS*COLS*PORTS*FLIT_W-1:0]                flit_out,
   input  logic [ROWS*COLS*PORTS-1:0]                       valid_out,
   output logic [ROWS*COLS*PORTS-1:0]                       err_dest,
   output logic [ROWS*COLS*PORTS-1:0]                       err_lat,
   output logic [ROWS*COLS*PORTS-1:0]                       err_ovf,
   output logic [ROWS*COLS*PORTS-1:0]                       err_spur,
   output logic                                             deadlock,
   output logic                                             first_err_vld,
   output logic [$clog2(ROWS*COLS*PORTS)-1:0]               first_err_ch,
   output logic [$clog2(ROWS*COLS*PORTS*TAG_DEPTH+1)-1:0]   outstanding,
   output logic [TS_W-1:0]                                  max_lat_seen
);

   localparam int N_CH    = ROWS * COLS * PORTS;
   localparam int CH_W    = $clog2(N_CH);
   localparam int PTR_W   = $clog2(TAG_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int OUT_W   = $clog2(N_CH * TAG_DEPTH + 1);
   localparam int STALL_W = $clog2(DL_TIMEOUT + 1);
   localparam int ENT_W   = DEST_W + TS_W;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACTIVE   = 2'd1,
      S_STALLED  = 2'd2,
      S_DEADLOCK = 2'd3
   } state_t;

   logic [TS_W-1:0]    r_now;
   logic [N_CH-1:0]    w_ev_dest, w_ev_lat, w_ev_ovf, w_ev_spur, w_ev_any;
   logic [TS_W-1:0]    w_pop_age  [N_CH];
   logic [CNT_W-1:0]   w_cnt_next [N_CH];
   logic [N_CH-1:0]    r_err_dest, r_err_lat, r_err_ovf, r_err_spur;
   logic               r_first_vld;
   logic [CH_W-1:0]    r_first_ch, w_first_ch;
   logic [OUT_W-1:0]   r_outstanding, w_out_next;
   logic [TS_W-1:0]    r_max_lat, w_max_lat_next;
   state_t             r_state, w_state_next;
   logic [STALL_W-1:0] r_stall, w_stall_next;
   logic               w_unused_flit;

   // only the destination field of each flit is tracked
   assign w_unused_flit = ^{flit_in, flit_out};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_now <= '0;
      else        r_now <= r_now + TS_W'(1);
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [ENT_W-1:0]  r_mem [TAG_DEPTH];
      logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
      logic [CNT_W-1:0]  r_cnt;
      logic              w_empty, w_full, w_push_req, w_pop_req, w_push, w_pop;
      logic [DEST_W-1:0] w_head_dest;
      logic [TS_W-1:0]   w_head_ts, w_age;

      assign w_empty    = (r_cnt == '0);
      assign w_full     = (r_cnt == CNT_W'(TAG_DEPTH));
      assign w_push_req = enable & valid_in[i] & ~clear;
      assign w_pop_req  = enable & valid_out[i] & ~clear;
      assign w_pop      = w_pop_req & ~w_empty;
      // a same-cycle pop frees the slot, so a full FIFO still accepts the push
      assign w_push     = w_push_req & (~w_full | w_pop);
      assign {w_head_dest, w_head_ts} = r_mem[r_rd_ptr];
      assign w_age      = r_now - w_head_ts;

      assign w_ev_dest[i]  = w_pop & (flit_out[i*FLIT_W +: DEST_W] != w_head_dest);
      assign w_ev_ovf[i]   = w_push_req & ~w_push;
      assign w_ev_spur[i]  = w_pop_req & w_empty;
      assign w_ev_lat[i]   = ~clear & ~w_empty & (w_age > TS_W'(MAX_LAT));
      assign w_pop_age[i]  = w_pop ? w_age : '0;
      assign w_cnt_next[i] = clear             ? '0 :
                             (w_push & ~w_pop) ? r_cnt + CNT_W'(1) :
                             (w_pop & ~w_push) ? r_cnt - CNT_W'(1) : r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
         end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt <= w_cnt_next[i];
         end
      end

      always_ff @(posedge clk) begin
         if (w_push) r_mem[r_wr_ptr] <= {flit_in[i*FLIT_W +: DEST_W], r_now};
      end
   end

   assign w_ev_any = w_ev_dest | w_ev_lat | w_ev_ovf | w_ev_spur;

   always_comb begin
      w_first_ch = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_ev_any[i]) w_first_ch = CH_W'(i);
      end
   end

   always_comb begin
      w_max_lat_next = r_max_lat;
      for (int i = 0; i < N_CH; i++) begin
         if (w_pop_age[i] > w_max_lat_next) w_max_lat_next = w_pop_age[i];
      end
   end

   always_comb begin
      w_out_next = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_out_next = w_out_next + OUT_W'(w_cnt_next[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_dest    <= '0;
         r_err_lat     <= '0;
         r_err_ovf     <= '0;
         r_err_spur    <= '0;
         r_first_vld   <= 1'b0;
         r_first_ch    <= '0;
         r_outstanding <= '0;
         r_max_lat     <= '0;
      end else if (clear) begin
         r_err_dest    <= '0;
         r_err_lat     <= '0;
         r_err_ovf     <= '0;
         r_err_spur    <= '0;
         r_first_vld   <= 1'b0;
         r_first_ch    <= '0;
         r_outstanding <= '0;
         r_max_lat     <= '0;
      end else begin
         r_err_dest    <= r_err_dest | w_ev_dest;
         r_err_lat     <= r_err_lat  | w_ev_lat;
         r_err_ovf     <= r_err_ovf  | w_ev_ovf;
         r_err_spur    <= r_err_spur | w_ev_spur;
         r_outstanding <= w_out_next;
         r_max_lat     <= w_max_lat_next;
         if (!r_first_vld && (|w_ev_any)) begin
            r_first_vld <= 1'b1;
            r_first_ch  <= w_first_ch;
         end
      end
   end

   // deadlock FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_stall <= '0;
      end else if (clear) begin
         r_state <= S_IDLE;
         r_stall <= '0;
      end else begin
         r_state <= w_state_next;
         r_stall <= w_stall_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_stall_next = r_stall;
      if (enable) begin
         case (r_state)
            S_IDLE: begin
               if (r_outstanding != '0) w_state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
               if (r_outstanding == '0) begin
                  w_state_next = S_IDLE;
               end else if (!(|valid_out)) begin
                  w_state_next = S_STALLED;
                  w_stall_next = STALL_W'(1);
               end
            end
            S_STALLED: begin
               if (|valid_out)                             w_state_next = S_ACTIVE;
               else if (r_outstanding == '0)               w_state_next = S_IDLE;
               else if (r_stall == STALL_W'(DL_TIMEOUT))   w_state_next = S_DEADLOCK;
               else                                        w_stall_next = r_stall + STALL_W'(1);
            end
            S_DEADLOCK: w_state_next = S_DEADLOCK;
            default:    w_state_next = S_IDLE;
         endcase
      end
   end

   assign err_dest      = r_err_dest;
   assign err_lat       = r_err_lat;
   assign err_ovf       = r_err_ovf;
   assign err_spur      = r_err_spur;
   assign deadlock      = (r_state == S_DEADLOCK);
   assign first_err_vld = r_first_vld;
   assign first_err_ch  = r_first_ch;
   assign outstanding   = r_outstanding;
   assign max_lat_seen  = r_max_lat;

endmodule
`default_nettype wire

// File: tb/tb_noc_flow_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_flow_monitor
// Brief    : bench for noc_flow_monitor; a tag model queues expected status each
//            cycle and the queue is drained against the DUT after the edge
// Revision : 1.0
// ============================================================================
module tb_noc_flow_monitor;

   localparam int ROWS       = 2;
   localparam int COLS       = 2;
   localparam int PORTS      = 5;
   localparam int FLIT_W     = 64;
   localparam int DEST_W     = 16;
   localparam int TAG_DEPTH  = 8;
   localparam int TS_W       = 12;   // short timestamp so the wrap case comes quickly
   localparam int MAX_LAT    = 256;
   localparam int DL_TIMEOUT = 1024;
   localparam int N_CH       = ROWS * COLS * PORTS;
   localparam int CH_W       = $clog2(N_CH);
   localparam int OUT_W      = $clog2(N_CH * TAG_DEPTH + 1);
   localparam int TS_MASK    = (1 << TS_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst_n, enable, clear;
   logic [N_CH*FLIT_W-1:0]  flit_in, flit_out;
   logic [N_CH-1:0]         valid_in, valid_out;
   logic [N_CH-1:0]         err_dest, err_lat, err_ovf, err_spur;
   logic                    deadlock, first_err_vld;
   logic [CH_W-1:0]         first_err_ch;
   logic [OUT_W-1:0]        outstanding;
   logic [TS_W-1:0]         max_lat_seen;

   noc_flow_monitor #(
      .ROWS(ROWS), .COLS(COLS), .PORTS(PORTS), .FLIT_W(FLIT_W), .DEST_W(DEST_W),
      .TAG_DEPTH(TAG_DEPTH), .TS_W(TS_W), .MAX_LAT(MAX_LAT), .DL_TIMEOUT(DL_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .flit_in(flit_in), .valid_in(valid_in), .flit_out(flit_out), .valid_out(valid_out),
      .err_dest(err_dest), .err_lat(err_lat), .err_ovf(err_ovf), .err_spur(err_spur),
      .deadlock(deadlock), .first_err_vld(first_err_vld), .first_err_ch(first_err_ch),
      .outstanding(outstanding), .max_lat_seen(max_lat_seen)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N_CH-1:0] dest, lat, ovf, spur;
      logic            fv;
      logic [CH_W-1:0] fc;
      int              out;
      int              mx;
   } snap_t;

   int              n_total = 0;
   int              n_bad   = 0;
   int              tnow    = 0;
   logic [15:0]     in_dest  [N_CH];
   logic [15:0]     out_dest [N_CH];
   logic [31:0]     tq [N_CH][$];
   snap_t           exp_q[$];
   logic [N_CH-1:0] m_dest, m_lat, m_ovf, m_spur;
   logic            m_fv;
   logic [CH_W-1:0] m_fc;
   int              m_max;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) tq[c].delete();
      m_dest = '0; m_lat = '0; m_ovf = '0; m_spur = '0;
      m_fv = 1'b0; m_fc = '0; m_max = 0;
   endtask

   // tag model for one clock edge, using the inputs currently driven
   task automatic model_eval();
      logic [31:0] head;
      int occ, age, first;
      bit popped, ev, any;
      any = 0; first = 0;
      if (clear) begin
         model_reset();
      end else begin
         for (int c = N_CH - 1; c >= 0; c--) begin
            ev = 0; popped = 0; occ = tq[c].size();
            if (occ > 0) begin
               head = tq[c][0];
               age = (tnow - int'(head[15:0])) & TS_MASK;
               if (age > MAX_LAT) begin m_lat[c] = 1'b1; ev = 1; end
            end
            if (enable && valid_out[c]) begin
               if (occ == 0) begin
                  m_spur[c] = 1'b1; ev = 1;
               end else begin
                  head = tq[c].pop_front(); popped = 1;
                  if (head[31:16] != out_dest[c]) begin m_dest[c] = 1'b1; ev = 1; end
                  age = (tnow - int'(head[15:0])) & TS_MASK;
                  if (age > m_max) m_max = age;
               end
            end
            if (enable && valid_in[c]) begin
               if (occ < TAG_DEPTH || popped) tq[c].push_back({in_dest[c], 16'(tnow)});
               else begin m_ovf[c] = 1'b1; ev = 1; end
            end
            if (ev) begin any = 1; first = c; end
         end
         if (any && !m_fv) begin m_fv = 1'b1; m_fc = CH_W'(first); end
      end
   endtask

   task automatic step();
      snap_t s;
      int    tot;
      for (int c = 0; c < N_CH; c++) begin
         flit_in[c*FLIT_W +: FLIT_W]  = {48'(c) ^ 48'hA5A5_5A5A_0F0F, in_dest[c]};
         flit_out[c*FLIT_W +: FLIT_W] = {48'(c) ^ 48'h3C3C_C3C3_F0F0, out_dest[c]};
      end
      model_eval();
      tot = 0;
      for (int c = 0; c < N_CH; c++) tot += tq[c].size();
      s.dest = m_dest; s.lat = m_lat; s.ovf = m_ovf; s.spur = m_spur;
      s.fv = m_fv; s.fc = m_fc; s.out = tot; s.mx = m_max;
      exp_q.push_back(s);
      @(posedge clk);
      tnow = (tnow + 1) & TS_MASK;
      #1;
      while (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         check_val("err_dest", 64'(err_dest), 64'(s.dest));
         check_val("err_lat", 64'(err_lat), 64'(s.lat));
         check_val("err_ovf", 64'(err_ovf), 64'(s.ovf));
         check_val("err_spur", 64'(err_spur), 64'(s.spur));
         check_val("first_err_vld", 64'(first_err_vld), 64'(s.fv));
         check_val("first_err_ch", 64'(first_err_ch), 64'(s.fc));
         check_val("outstanding", 64'(outstanding), 64'(s.out));
         check_val("max_lat_seen", 64'(max_lat_seen), 64'(s.mx));
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_errs"}, 64'({err_dest, err_lat, err_ovf, err_spur}), 64'd0);
      check_val({tag, "_status"}, 64'({deadlock, first_err_vld, first_err_ch}), 64'd0);
      check_val({tag, "_counts"}, 64'({outstanding, max_lat_seen}), 64'd0);
   endtask

   // hold one ch1 tag: age 256 is tolerated, age 257 flags err_lat
   task automatic lat_probe(input string tag);
      valid_in[1] = 1'b1; in_dest[1] = 16'h0033;
      step();
      valid_in = '0;
      repeat (256) step();
      check_val({tag, "_age256"}, 64'(err_lat[1]), 64'd0);
      step();
      check_val({tag, "_age257"}, 64'(err_lat[1]), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
      valid_in = '0; valid_out = '0; flit_in = '0; flit_out = '0;
      for (int c = 0; c < N_CH; c++) begin in_dest[c] = '0; out_dest[c] = '0; end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      tnow = 0;

      // 1: clean flit with latency 5
      valid_in[0] = 1'b1; in_dest[0] = 16'h0012;
      step();
      valid_in = '0;
      check_val("t1_out_after_push", 64'(outstanding), 64'd1);
      repeat (4) step();
      valid_out[0] = 1'b1; out_dest[0] = 16'h0012;
      step();
      valid_out = '0;
      check_val("t1_out_after_pop", 64'(outstanding), 64'd0);
      check_val("t1_max_lat", 64'(max_lat_seen), 64'd5);
      check_val("t1_no_err", 64'(first_err_vld), 64'd0);

      // 2: destination mismatch on ch3
      do_clear();
      valid_in[3] = 1'b1; in_dest[3] = 16'h0009;
      step();
      valid_in = '0;
      valid_out[3] = 1'b1; out_dest[3] = 16'h0007;
      step();
      valid_out = '0;
      check_val("t2_err_dest3", 64'(err_dest[3]), 64'd1);
      check_val("t2_first_vld", 64'(first_err_vld), 64'd1);
      check_val("t2_first_ch", 64'(first_err_ch), 64'd3);

      // 3: latency bound, then again straddling the timestamp wrap
      do_clear();
      lat_probe("t3");
      do_clear();
      while (tnow != (1 << TS_W) - 100) step();
      lat_probe("t3_wrap");

      // 4: overflow on the 9th push; full FIFO with same-cycle pop accepts the push
      do_clear();
      valid_in[2] = 1'b1;
      for (int k = 0; k < TAG_DEPTH; k++) begin
         in_dest[2] = 16'h0100 + 16'(k);
         step();
      end
      check_val("t4_no_ovf_at_8", 64'(err_ovf[2]), 64'd0);
      in_dest[2] = 16'h01FF;
      step();
      valid_in = '0;
      check_val("t4_ovf_at_9", 64'(err_ovf[2]), 64'd1);
      check_val("t4_out_8", 64'(outstanding), 64'd8);
      do_clear();
      valid_in[2] = 1'b1;
      for (int k = 0; k < TAG_DEPTH; k++) begin
         in_dest[2] = 16'h0100 + 16'(k);
         step();
      end
      in_dest[2] = 16'h0200;
      valid_out[2] = 1'b1; out_dest[2] = 16'h0100;
      step();
      valid_in = '0; valid_out = '0;
      check_val("t4_full_pushpop_ovf", 64'(err_ovf[2]), 64'd0);
      check_val("t4_full_pushpop_out", 64'(outstanding), 64'd8);

      // 5: push at edge P; ACTIVE at P+1, STALLED at P+2, DEADLOCK 1024 edges later
      do_clear();
      valid_in[0] = 1'b1; in_dest[0] = 16'h0044;
      step();
      valid_in = '0;
      repeat (1025) step();
      check_val("t5_dl_early", 64'(deadlock), 64'd0);
      step();
      check_val("t5_dl_set", 64'(deadlock), 64'd1);
      step();
      check_val("t5_dl_sticky", 64'(deadlock), 64'd1);
      do_clear();
      check_val("t5_dl_cleared", 64'(deadlock), 64'd0);
      check_val("t5_out_cleared", 64'(outstanding), 64'd0);

      // 6: enable gating, tie-break, spurious egress, async reset mid-traffic
      enable = 1'b0; valid_in[6] = 1'b1; in_dest[6] = 16'h0666;
      step();
      enable = 1'b1; valid_in = '0;
      check_val("t6_disabled_out", 64'(outstanding), 64'd0);
      valid_out[9] = 1'b1; valid_out[6] = 1'b1;
      step();
      valid_out = '0;
      check_val("t6_tie_first_ch", 64'(first_err_ch), 64'd6);
      do_clear();
      valid_out[5] = 1'b1;
      step();
      valid_out = '0;
      check_val("t6_spur5", 64'(err_spur[5]), 64'd1);
      check_val("t6_first_ch5", 64'(first_err_ch), 64'd5);
      valid_in[0] = 1'b1; valid_in[7] = 1'b1;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_async_reset");
      model_reset();
      valid_in = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tnow = 0;
      valid_in[4] = 1'b1; in_dest[4] = 16'h0055;
      step();
      valid_in = '0;
      step();
      valid_out[4] = 1'b1; out_dest[4] = 16'h0055;
      step();
      valid_out = '0;
      check_val("t6_post_reset_max", 64'(max_lat_seen), 64'd2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
